bin2sseg_conv: RTL and testbench
================================

// Module: bin2sseg_conv
// PURPOSE
//  Upstream producer for the 4-digit seven-segment multiplexer. Accepts a binary
//  value over a valid/ready handshake, converts it to 4 BCD digits by sequential
//  double-dabble (one shift per clock), and encodes each digit to segment patterns.
//  The registered dig0..dig3 outputs drive the mux's digit inputs directly and hold
//  their value until the next conversion completes.
// PARAMETERS
//  IN_BITS  14  width of input value; legal range 4..14 (max 16383)
//  LZB      1   1 = blank leading zeros on dig3..dig1; dig0 is never blanked
// PORTS
//  clk       in   1        system clock (100 MHz)
//  rst       in   1        synchronous, active-low reset
//  in_data   in   IN_BITS  binary value to display
//  in_valid  in   1        in_data valid
//  in_ready  out  1        block idle, can accept
//  done      out  1        one-cycle pulse: dig0..dig3 just updated
//  dig0      out  7        ones digit segments {g,f,e,d,c,b,a}, active-low
//  dig1      out  7        tens digit, same encoding
//  dig2      out  7        hundreds digit, same encoding
//  dig3      out  7        thousands digit, same encoding
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, in_ready=1, done=0, dig0..dig3=7'b1111111
//    (blank). Reset mid-conversion aborts; partial result discarded, never shown.
//  - Handshake: transfer on posedge with in_valid&&in_ready. in_ready=1 only in IDLE;
//    in_valid while busy is ignored (no queueing). in_data sampled only at transfer.
//  - States: IDLE -> SHIFT (on transfer; load shift reg {16'b0, in_data}, cnt=0)
//    SHIFT: each cycle add 3 to every BCD nibble >=5, then shift left 1; cnt++;
//    after IN_BITS shifts -> LOAD. LOAD: encode, register dig0..dig3, done=1 next
//    cycle, -> IDLE.
//  - Latency: accept at edge E0; digits and done change at edge E(IN_BITS+1)
//    (E15 for default); in_ready high again in the same cycle done is high.
//    Throughput: one conversion per IN_BITS+2 cycles.
//  - Overflow: if captured value >9999, all four digits = dash 7'b0111111.
//  - LZB=1: digit k (k=3..1) blanked iff it and all higher digits are 0.
//    Value 0 -> dig0 shows '0'.
//  - Patterns (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 blank=1111111 dash=0111111.
//  - Outputs are registers only; no combinational path from inputs to outputs.
//  - Shift counter width = clog2(IN_BITS+1); no wrap in normal operation.
// STRUCTURE
//  - Shared header sseg_defs.vh: SEG_BLANK, SEG_DASH, SEG_0..SEG_9 localparams,
//    state encodings ST_IDLE/ST_SHIFT/ST_LOAD.
//  - Sub-module bcd_to_sseg (4-bit BCD in -> 7-bit active-low pattern out,
//    combinational, codes 10..15 -> SEG_BLANK), instantiated 4x.
//  - Top holds FSM, shift/BCD register, counter, blanking/overflow mux, output regs.
// TESTING
//  1. in_data=1234 accepted -> after 15 clks done=1; dig3=1111001 dig2=0100100
//     dig1=0110000 dig0=0011001; outputs stable until next transfer.
//  2. LZB=1, in_data=0 -> dig0=1000000, dig1..dig3=1111111; in_data=7 -> dig0=1111000,
//     rest blank; in_data=9999 -> all 0010000; in_data=1005 -> dig2,dig1 show '0'.
//  3. in_data=10000 and 16383 -> all digits 0111111; done pulses once each.
//  4. in_valid held high continuously with changing data -> in_ready low for 15
//     cycles after each accept; only values present at in_ready=1 edges displayed.
//  5. rst=0 asserted 7 clks into a conversion -> next edge: digits blank, done=0,
//     in_ready=1; no done pulse for aborted value; new value converts normally.
//  6. Check done width exactly 1 clk and accept->done = IN_BITS+1 clks for
//     IN_BITS=14 and IN_BITS=8 (in_data=255 -> dig2..dig0 = 2,5,5, dig3 blank).

Source files
------------

// File: rtl/bin2sseg_conv_pkg.sv
// Shared segment patterns, FSM states and the double-dabble adjust step
// for the binary to seven-segment converter.
package bin2sseg_conv_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD
    } state_t;

    function automatic logic [15:0] bcd_add3(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3
                                                : b[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2sseg_conv_bcd_to_sseg.sv
// One BCD digit to an active-low {g,f,e,d,c,b,a} pattern.
// Non-decimal codes show as blank.
module bcd_to_sseg
    import bin2sseg_conv_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2sseg_conv.sv
// Binary value in over valid/ready, four registered seven-segment digits out.
// Sequential double-dabble, one shift per clock.
module bin2sseg_conv
    import bin2sseg_conv_pkg::*;
#(
    parameter int IN_BITS = 14,
    parameter bit LZB     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               done,
    output logic [6:0]         dig0,
    output logic [6:0]         dig1,
    output logic [6:0]         dig2,
    output logic [6:0]         dig3
);

    localparam int CW = $clog2(IN_BITS + 1);

    state_t             state;
    state_t             state_nx;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [IN_BITS-1:0] bin;
    logic [CW-1:0]      cnt;
    logic               ovf;
    logic               last;
    logic [6:0]         seg_raw [4];
    logic [6:0]         disp [4];
    logic [3:0]         zero;
    logic [3:0]         blank;

    assign in_ready = (state == ST_IDLE);
    assign last     = (cnt == CW'(IN_BITS - 1));
    assign bcd_adj  = bcd_add3(bcd);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nx = ST_SHIFT;
            ST_SHIFT: if (last)     state_nx = ST_LOAD;
            ST_LOAD:                state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    bcd <= '0;
                    bin <= in_data;
                    cnt <= '0;
                    ovf <= 32'(in_data) > 32'd9999;
                end
                ST_SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_enc
        bcd_to_sseg u_enc (
            .bcd (bcd[4*g +: 4]),
            .seg (seg_raw[g])
        );
        assign zero[g] = (bcd[4*g +: 4] == 4'd0);
    end

    // A digit blanks only when it and everything above it is zero.
    assign blank[3] = LZB && zero[3];
    assign blank[2] = blank[3] && zero[2];
    assign blank[1] = blank[2] && zero[1];
    assign blank[0] = 1'b0;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            disp[k] = ovf      ? SEG_DASH  :
                      blank[k] ? SEG_BLANK : seg_raw[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
            dig0 <= SEG_BLANK;
            dig1 <= SEG_BLANK;
            dig2 <= SEG_BLANK;
            dig3 <= SEG_BLANK;
        end else begin
            done <= (state == ST_LOAD);
            if (state == ST_LOAD) begin
                dig0 <= disp[0];
                dig1 <= disp[1];
                dig2 <= disp[2];
                dig3 <= disp[3];
            end
        end
    end

endmodule

// File: tb/tb_bin2sseg_conv.sv
// Directed bench for bin2sseg_conv: table of values plus streaming,
// reset-abort and narrow-width sequences.
module tb_bin2sseg_conv;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    typedef struct {
        logic [13:0] val;
        logic [27:0] segs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic        a_done;
    logic [6:0]  a_d0, a_d1, a_d2, a_d3;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic        b_done;
    logic [6:0]  b_d0, b_d1, b_d2, b_d3;

    int total = 0;
    int bad   = 0;

    vec_t va [11];
    vec_t vb [3];

    always #5 clk = ~clk;

    bin2sseg_conv #(.IN_BITS(14), .LZB(1'b1)) u_a (
        .clk      (clk),
        .rst      (rst),
        .in_data  (a_data),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .done     (a_done),
        .dig0     (a_d0),
        .dig1     (a_d1),
        .dig2     (a_d2),
        .dig3     (a_d3)
    );

    bin2sseg_conv #(.IN_BITS(8), .LZB(1'b1)) u_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  (b_data),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .done     (b_done),
        .dig0     (b_d0),
        .dig1     (b_d1),
        .dig2     (b_d2),
        .dig3     (b_d3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? b_ready : a_ready;
    endfunction

    function automatic logic dn(input bit s);
        return s ? b_done : a_done;
    endfunction

    function automatic logic [27:0] segs(input bit s);
        return s ? {b_d3, b_d2, b_d1, b_d0} : {a_d3, a_d2, a_d1, a_d0};
    endfunction

    task automatic run(input bit s, input logic [13:0] v,
                       input logic [27:0] exp, input int lat_exp);
        int lat;
        int w;
        bit busy_rdy;
        w = 0;
        @(negedge clk);
        while (!rdy(s) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("idle %0d", v), 32'(rdy(s)), 32'd1);
        if (s) begin
            b_data  = v[7:0];
            b_valid = 1'b1;
        end else begin
            a_data  = v;
            a_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        lat      = 0;
        busy_rdy = 1'b0;
        while (!dn(s) && lat < 40) begin
            if (rdy(s)) busy_rdy = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency %0d", v), 32'(lat), 32'(lat_exp));
        chk($sformatf("busy ready %0d", v), 32'(busy_rdy), 32'd0);
        chk($sformatf("digits %0d", v), 32'(segs(s)), 32'(exp));
        chk($sformatf("ready at done %0d", v), 32'(rdy(s)), 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("done width %0d", v), 32'(dn(s)), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("hold %0d", v), 32'(segs(s)), 32'(exp));
    endtask

    initial begin
        bit seen;

        va[0]  = '{14'd1234,  {P1, P2, P3, P4}};
        va[1]  = '{14'd0,     {BL, BL, BL, P0}};
        va[2]  = '{14'd7,     {BL, BL, BL, P7}};
        va[3]  = '{14'd9999,  {P9, P9, P9, P9}};
        va[4]  = '{14'd1005,  {P1, P0, P0, P5}};
        va[5]  = '{14'd10000, {DS, DS, DS, DS}};
        va[6]  = '{14'd16383, {DS, DS, DS, DS}};
        va[7]  = '{14'd42,    {BL, BL, P4, P2}};
        va[8]  = '{14'd100,   {BL, P1, P0, P0}};
        va[9]  = '{14'd9000,  {P9, P0, P0, P0}};
        va[10] = '{14'd5,     {BL, BL, BL, P5}};

        vb[0] = '{14'd255, {BL, P2, P5, P5}};
        vb[1] = '{14'd0,   {BL, BL, BL, P0}};
        vb[2] = '{14'd106, {BL, P1, P0, P6}};

        rst     = 1'b0;
        a_data  = '0;
        a_valid = 1'b0;
        b_data  = '0;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset digits a", 32'(segs(0)), 32'({BL, BL, BL, BL}));
        chk("reset digits b", 32'(segs(1)), 32'({BL, BL, BL, BL}));
        chk("reset done", 32'({a_done, b_done}), 32'd0);
        chk("reset ready", 32'({a_ready, b_ready}), 32'd3);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) run(1'b0, va[i].val, va[i].segs, 15);
        for (int i = 0; i < 3; i++)  run(1'b1, vb[i].val, vb[i].segs, 9);

        // in_valid held high; data changes every cycle
        for (int c = 0; c <= 31; c++) begin
            @(negedge clk);
            a_data  = 14'(3000 + c);
            a_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("stream done c%0d", c), 32'(a_done),
                32'(c == 15 || c == 31));
            chk($sformatf("stream ready c%0d", c), 32'(a_ready),
                32'(c == 15 || c == 31));
            if (c == 15)
                chk("stream 3000", 32'(segs(0)), 32'({P3, P0, P0, P0}));
            if (c == 31)
                chk("stream 3016", 32'(segs(0)), 32'({P3, P0, P1, P6}));
        end
        a_valid = 1'b0;

        // reset seven clocks into a conversion
        @(negedge clk);
        a_data  = 14'd4321;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort digits", 32'(segs(0)), 32'({BL, BL, BL, BL}));
        chk("abort done", 32'(a_done), 32'd0);
        chk("abort ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (a_done) seen = 1'b1;
        end
        chk("abort no done", 32'(seen), 32'd0);
        chk("abort still blank", 32'(segs(0)), 32'({BL, BL, BL, BL}));
        run(1'b0, 14'd58, {BL, BL, P5, P8}, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
